// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encodings and default sizing.
package mux_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_DWELL  = 1;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan sequencer (slave side) and its driver/mux loop (master side).
interface mux_scan_ctrl_if #(
  parameter int unsigned DATA_W = mux_scan_ctrl_pkg::DEF_DATA_W
);
  localparam int unsigned SEL_W = $clog2(DATA_W);

  logic              start;
  logic [DATA_W-1:0] d_in;
  logic              f_in;
  logic [DATA_W-1:0] d;
  logic [SEL_W-1:0]  s;
  logic              s_valid;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rd_word;

  modport master (
    output start, d_in, f_in,
    input  d, s, s_valid, busy, done, rd_word
  );

  modport slave (
    input  start, d_in, f_in,
    output d, s, s_valid, busy, done, rd_word
  );

endinterface

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the final cycle of each select step.
module mux_dwell_cnt #(
  parameter int unsigned DWELL = mux_scan_ctrl_pkg::DEF_DWELL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int unsigned CNT_W = $clog2(DWELL + 1);

  logic [CNT_W-1:0] r_cnt;

  assign last = (r_cnt == CNT_W'(DWELL - 1));

  // Self-wraps on the last cycle so the next step starts from 0 without a separate clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 select mux: holds a word on d, walks s, rebuilds f samples into rd_word.
// Optional feature macro MUX_SCAN_CONT_EN: allows a start in DONE to launch the next scan directly.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DWELL  = DEF_DWELL
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(DATA_W);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DATA_W - 1);

  scan_state_e       r_state;
  scan_state_e       w_next;
  logic              w_accept;
  logic              w_last;
  logic              w_scan;
  logic [DATA_W-1:0] r_d;
  logic [SEL_W-1:0]  r_s;
  logic [DATA_W-1:0] r_rd_word;

  assign w_scan = (r_state == ST_SCAN);

  mux_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .en   (w_scan),
    .last (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    bus.s_valid  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        bus.s_valid = 1'b1;
        bus.busy    = 1'b1;
        if (w_last && (r_s == SEL_LAST)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.done = 1'b1;
        w_next   = ST_IDLE;
`ifdef MUX_SCAN_CONT_EN
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = ST_SCAN;
        end
`endif
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // f_in is sampled in the same cycle s is presented; s parks at the last index after the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d       <= '0;
      r_s       <= '0;
      r_rd_word <= '0;
    end else if (w_accept) begin
      r_d       <= bus.d_in;
      r_s       <= '0;
      r_rd_word <= '0;
    end else if (w_scan && w_last) begin
      r_rd_word[r_s] <= bus.f_in;
      if (r_s != SEL_LAST) begin
        r_s <= r_s + 1'b1;
      end
    end
  end

  assign bus.d       = r_d;
  assign bus.s       = r_s;
  assign bus.rd_word = r_rd_word;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (DWELL=1 and DWELL=3) with a modelled mux in the loop.
module tb_mux_scan_ctrl;

  typedef struct {
    logic [3:0] word;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fault_a = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  mux_scan_ctrl_if #(.DATA_W(4)) a_if ();
  mux_scan_ctrl_if #(.DATA_W(4)) b_if ();

  mux_scan_ctrl #(.DATA_W(4), .DWELL(1)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  mux_scan_ctrl #(.DATA_W(4), .DWELL(3)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // Combinational 4:1 mux model closing the loop; fault_a forces f low on instance A.
  assign a_if.f_in = fault_a ? 1'b0 : a_if.d[a_if.s];
  assign b_if.f_in = b_if.d[b_if.s];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && a_if.done) begin
      if (qa.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        check("a_rd_word", 32'(a_if.rd_word), 32'(e.word));
        check("a_done_cyc", 32'(cyc), 32'(e.cyc));
        check("a_done_flags", {a_if.busy, a_if.s_valid, a_if.s}, {1'b0, 1'b0, 2'd3});
      end
    end
    if (!rst && b_if.done) begin
      if (qb.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("b_rd_word", 32'(b_if.rd_word), 32'(e.word));
        check("b_done_cyc", 32'(cyc), 32'(e.cyc));
        check("b_done_flags", {b_if.busy, b_if.s_valid, b_if.s}, {1'b0, 1'b0, 2'd3});
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      check("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_a_zero(input string tag);
    check(tag, {a_if.d, a_if.s, a_if.s_valid, a_if.busy, a_if.done, a_if.rd_word}, '0);
  endtask

  initial begin
    a_if.start = 1'b0; a_if.d_in = '0;
    b_if.start = 1'b0; b_if.d_in = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_a_zero("reset_a");
    check("reset_b", {b_if.d, b_if.s, b_if.s_valid, b_if.busy, b_if.done, b_if.rd_word}, '0);
    rst = 1'b0;

    // Reset mid-scan
    @(negedge clk);
    a_if.start = 1'b1; a_if.d_in = 4'b1100;
    @(negedge clk);
    a_if.start = 1'b0;
    @(negedge clk);
    check("midscan_busy", 32'(a_if.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_a_zero("rst_mid_1");
    @(negedge clk);
    check_a_zero("rst_mid_2");
    rst = 1'b0;
    @(negedge clk);
    check_a_zero("rst_release");

    // Basic scan, DWELL=1, with per-cycle select walk
    a_if.start = 1'b1; a_if.d_in = 4'b1010;
    qa.push_back('{4'b1010, cyc + 5});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) a_if.start = 1'b0;
      check("basic_s", {a_if.s_valid, a_if.busy, a_if.s}, {1'b1, 1'b1, 2'(k - 1)});
    end
    drain(20);

    // Dwell scan, DWELL=3
    b_if.start = 1'b1; b_if.d_in = 4'b0110;
    qb.push_back('{4'b0110, cyc + 13});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) b_if.start = 1'b0;
      check("dwell_s", 32'(b_if.s), 32'((k - 1) / 3));
    end
    drain(20);

    // Start and d_in changes during SCAN are ignored
    b_if.start = 1'b1; b_if.d_in = 4'b0110;
    qb.push_back('{4'b0110, cyc + 13});
    @(negedge clk);
    b_if.start = 1'b0;
    @(negedge clk);
    b_if.start = 1'b1; b_if.d_in = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("ignore_d", 32'(b_if.d), 32'(4'b0110));
    end
    b_if.start = 1'b0;
    drain(30);
    check("ignore_d_after", 32'(b_if.d), 32'(4'b0110));

    // Stuck-at-0 mux output: rd_word must diverge from d
    fault_a = 1'b1;
    a_if.start = 1'b1; a_if.d_in = 4'b1010;
    qa.push_back('{4'b0000, cyc + 5});
    @(negedge clk);
    a_if.start = 1'b0;
    drain(20);
    check("fault_detected", 32'(a_if.rd_word != a_if.d), 32'd1);
    fault_a = 1'b0;

    // Start held high across two scans
    a_if.start = 1'b1; a_if.d_in = 4'b1010;
    qa.push_back('{4'b1010, cyc + 5});
`ifdef MUX_SCAN_CONT_EN
    qa.push_back('{4'b0101, cyc + 10});
`else
    qa.push_back('{4'b0101, cyc + 11});
`endif
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) a_if.d_in = 4'b0101;
    end
    a_if.start = 1'b0;
    drain(30);
    repeat (3) @(negedge clk);
    check("final_idle_a", {a_if.busy, a_if.done, a_if.s_valid}, '0);
    check("final_d_a", 32'(a_if.d), 32'(4'b0101));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
